// File: rtl/prg_loader.sv
// Serial program loader: oversampled 3-wire frame {auto, addr, data} in, single-cycle
// code RAM write out, core held while programming.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | programming disabled; pin edges ignored, status readable
// S_SHIFT | collecting frame bits on sclk, committing on latch
// S_WRITE | one cycle; issues the RAM write and updates status
module prg_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              prg_en,
  input  logic              prg_din,
  input  logic              prg_sclk,
  input  logic              prg_latch,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WRITE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_din_sync, r_sclk_sync, r_latch_sync;
  logic                   r_din_d, r_sclk_d, r_latch_d;
  logic                   r_sclk_rise, r_latch_rise;

  logic [FRAME_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [ADDR_W-1:0]  r_ptr;
  logic               r_mem_we, r_core_hold, r_frame_err;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata, r_checksum;
  logic [ADDR_W:0]    r_word_count;

  logic               w_frame_ok;
  logic               w_auto;
  logic [ADDR_W-1:0]  w_addr_f, w_wr_addr;
  logic [DATA_W-1:0]  w_data_f;

  // Edge pulses are registered so din, sclk and latch all see the same depth.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_din_sync   <= '0;
      r_sclk_sync  <= '0;
      r_latch_sync <= '0;
      r_din_d      <= 1'b0;
      r_sclk_d     <= 1'b0;
      r_latch_d    <= 1'b0;
      r_sclk_rise  <= 1'b0;
      r_latch_rise <= 1'b0;
    end else begin
      r_din_sync   <= {r_din_sync[SYNC_STAGES-2:0], prg_din};
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], prg_sclk};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], prg_latch};
      r_din_d      <= r_din_sync[SYNC_STAGES-1];
      r_sclk_d     <= r_sclk_sync[SYNC_STAGES-1];
      r_latch_d    <= r_latch_sync[SYNC_STAGES-1];
      r_sclk_rise  <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
      r_latch_rise <= r_latch_sync[SYNC_STAGES-1] & ~r_latch_d;
    end
  end

  assign w_frame_ok = (r_bit_cnt == CNT_FULL);
  assign w_auto     = r_shift[FRAME_W-1];
  assign w_addr_f   = r_shift[DATA_W +: ADDR_W];
  assign w_data_f   = r_shift[DATA_W-1:0];
  assign w_wr_addr  = w_auto ? r_ptr : w_addr_f;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (prg_en) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (!prg_en)                         w_state_nxt = S_IDLE;
        else if (r_latch_rise && w_frame_ok) w_state_nxt = S_WRITE;
      end
      S_WRITE: w_state_nxt = prg_en ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_ptr        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_hold  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_core_hold <= prg_en | (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (prg_en) begin
            r_bit_cnt    <= '0;
            r_ptr        <= '0;
            r_frame_err  <= 1'b0;
            r_word_count <= '0;
            r_checksum   <= '0;
          end
        end
        S_SHIFT: begin
          if (!prg_en) begin
            r_bit_cnt <= '0;
          end else if (r_latch_rise) begin
            // A good latch leaves the count at FRAME_W until WRITE clears it.
            if (!w_frame_ok) begin
              r_frame_err <= 1'b1;
              r_bit_cnt   <= '0;
            end
          end else if (r_sclk_rise) begin
            r_shift <= {r_shift[FRAME_W-2:0], r_din_d};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_wr_addr;
          r_mem_wdata <= w_data_f;
          r_ptr       <= w_wr_addr + 1'b1;
          r_checksum  <= r_checksum ^ w_data_f;
          if (r_word_count != '1) r_word_count <= r_word_count + 1'b1;
          if (r_sclk_rise) begin
            r_shift   <= {r_shift[FRAME_W-2:0], r_din_d};
            r_bit_cnt <= CNT_W'(1);
          end else begin
            r_bit_cnt <= '0;
          end
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_hold  = r_core_hold;
  assign busy       = (r_bit_cnt != '0) | (r_state == S_WRITE);
  assign frame_err  = r_frame_err;
  assign word_count = r_word_count;
  assign checksum   = r_checksum;

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: stimulus pushes expected writes, a negedge monitor
// pops and compares them; status outputs are compared against a plain-arithmetic model.
module tb_prg_loader;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FW = 1 + AW + DW;
  localparam int PH = 4;

  logic          clk = 1'b0;
  logic          nreset, prg_en, din, sclk, latch;
  logic          mem_we, core_hold, busy, frame_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, checksum;
  logic [AW:0]   word_count;

  prg_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .nreset(nreset), .prg_en(prg_en), .prg_din(din), .prg_sclk(sclk),
    .prg_latch(latch), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .frame_err(frame_err),
    .word_count(word_count), .checksum(checksum));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: what the loader should report.
  int m_ptr, m_chk, m_cnt, m_err;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (nreset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), mon_e.addr);
        check("wr_data", int'(mem_wdata), mon_e.data);
        check("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m_ptr = 0; m_chk = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = val[i];
      tick(PH);
      sclk = 1'b1;
      tick(PH);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int auto_b, input int addr, input int data, input int nbits);
    logic [31:0] v;
    int a;
    if (nbits == FW) v = {15'd0, 1'(auto_b), 8'(addr), 8'(data)};
    else             v = $urandom;
    shift_bits(v, nbits);
    if (nbits == FW) begin
      a = (auto_b != 0) ? m_ptr : addr;
      // latch is first sampled at the next posedge; the write is SS+2 edges after that
      exp_q.push_back('{a, data, cyc + 1 + SS + 2});
      m_ptr = (a + 1) % (1 << AW);
      m_chk = m_chk ^ data;
      if (m_cnt < (1 << (AW + 1)) - 1) m_cnt++;
    end else begin
      m_err = 1;
    end
    latch = 1'b1;
    tick(PH);
    latch = 1'b0;
    tick(PH + 4);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_word_count"}, int'(word_count), m_cnt);
    check({tag, "_checksum"}, int'(checksum), m_chk);
    check({tag, "_frame_err"}, int'(frame_err), m_err);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, nb;
    nreset = 1'b0; prg_en = 1'b0; din = 1'b0; sclk = 1'b0; latch = 1'b0;
    model_clear();
    tick(3);
    nreset = 1'b1;
    repeat (12) begin
      din = 1'($urandom_range(0, 1));
      sclk = 1'($urandom_range(0, 1));
      latch = 1'($urandom_range(0, 1));
      tick(PH);
    end
    din = 1'b0; sclk = 1'b0; latch = 1'b0;
    tick(6);
    check("idle_core_hold", int'(core_hold), 0);
    check("idle_mem_addr", int'(mem_addr), 0);
    check("idle_mem_wdata", int'(mem_wdata), 0);
    check_status("idle");

    prg_en = 1'b1;
    check("hold_before_edge", int'(core_hold), 0);
    tick(1);
    check("hold_after_edge", int'(core_hold), 1);
    model_clear();

    send_frame(0, 8'h10, 8'hA5, FW);
    check_status("first");
    send_frame(1, 8'hFF, 8'h01, FW);
    send_frame(1, 8'h00, 8'h02, FW);
    send_frame(1, 8'h33, 8'h03, FW);
    check_status("auto3");
    check("auto3_chk_const", int'(checksum), 8'hA5);

    send_frame(0, 8'hFF, $urandom_range(0, 255), FW);
    send_frame(1, 8'h5A, $urandom_range(0, 255), FW);
    check_status("wrap");

    send_frame(0, 0, 0, 16);
    check_status("short");
    send_frame(0, 8'h42, 8'h3C, FW);
    check_status("after_short");
    send_frame(0, 0, 0, FW + 1);
    check_status("long");

    shift_bits($urandom, 9);
    check("mid_frame_busy", int'(busy), 1);
    prg_en = 1'b0;
    tick(1);
    check("drop_hold_1", int'(core_hold), 1);
    tick(1);
    check("drop_hold_0", int'(core_hold), 0);
    check_status("dropped");
    tick(4);
    prg_en = 1'b1;
    tick(2);
    model_clear();
    check_status("reenable");
    send_frame(1, 8'h77, 8'hC3, FW);
    check_status("reenable_frame");

    shift_bits($urandom, 9);
    nreset = 1'b0;
    #1;
    check("rst_core_hold", int'(core_hold), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_word_count", int'(word_count), 0);
    check("rst_checksum", int'(checksum), 0);
    check("rst_frame_err", int'(frame_err), 0);
    prg_en = 1'b0; din = 1'b0; sclk = 1'b0; latch = 1'b0;
    tick(3);
    nreset = 1'b1;
    tick(4);
    prg_en = 1'b1;
    tick(2);
    model_clear();

    repeat (30) begin
      r = $urandom_range(0, 11);
      nb = (r == 0) ? 16 : (r == 1) ? FW + 1 : FW;
      send_frame($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255), nb);
      if (r == 2) begin
        prg_en = 1'b0;
        tick($urandom_range(2, 6));
        check_status("rand_idle");
        prg_en = 1'b1;
        tick(2);
        model_clear();
      end
      check_status("rand");
    end

    tick(10);
    check("pending_writes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Parametrised serial program loader: successor to the fixed 16-bit shift-in programming port.
- Takes a 3-wire bit-banged frame from external pins (din, shift clock, latch) and oversamples all three in the system clock domain.
- Drives a single-cycle write port into code RAM and holds the core while programming.
- Adds configurable widths, address auto-increment mode, frame-length checking, a running checksum and a word counter.

Parameters:
- ADDR_W, 8, code RAM address width.
- DATA_W, 8, code RAM data width.
- SYNC_STAGES, 2, synchroniser flops per external pin (≥2).
- Derived FRAME_W = 1+ADDR_W+DATA_W: frame = {auto, addr, data}, sent MSB first.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- prg_en  in  1  programming mode request (synchronous to clk).
- prg_din  in  1  serial data pin (asynchronous).
- prg_sclk  in  1  serial shift clock pin (asynchronous).
- prg_latch  in  1  frame commit pin (asynchronous).
- mem_we  out  1  code RAM write strobe, one cycle.
- mem_addr  out  ADDR_W  code RAM write address.
- mem_wdata  out  DATA_W  code RAM write data.
- core_hold  out  1  stalls the core clock-enable while high.
- busy  out  1  frame in progress (bit count ≠ 0) or write cycle.
- frame_err  out  1  sticky; set on a bad-length frame.
- word_count  out  ADDR_W+1  writes since prg_en rose; saturates at all-ones.
- checksum  out  DATA_W  XOR of all data written since prg_en rose.

Behaviour:
- Reset (async, nreset=0): all outputs 0, synchronisers 0, shift register 0, bit count 0, pointer 0, state IDLE.
- Synchronisers: each pin passes SYNC_STAGES flops, then one edge-detect flop. Rising edges are detected only on the synchronised sclk and latch.
- States:
  - IDLE: entered while prg_en=0. Ignores pin edges. On prg_en=1 → SHIFT; clears word_count, checksum, frame_err, pointer and bit count.
  - SHIFT, on sclk rising edge: shift_reg <= {shift_reg[FRAME_W-2:0], din_sync}; bit count increments, saturating at FRAME_W+1.
  - SHIFT, on latch rising edge with bit count == FRAME_W → WRITE.
  - SHIFT, on latch rising edge with any other bit count: frame_err <= 1, frame discarded, bit count <= 0, stay in SHIFT, no write.
  - WRITE (exactly one cycle): mem_we=1.
    - auto=1: mem_addr = pointer; data field is written, address field ignored.
    - auto=0: mem_addr = addr field.
    - pointer <= mem_addr+1, wrapping modulo 2^ADDR_W.
    - checksum ^= data; word_count += 1 (saturating); bit count <= 0; → SHIFT.
- Simultaneous sclk and latch edges in one cycle: latch is processed and the sclk edge is discarded.
- Edges during WRITE: sclk edges shift normally; latch edges are dropped.
- prg_en falls in SHIFT: bit count cleared, partial frame discarded → IDLE. If it falls in WRITE, the write completes first → IDLE.
- mem_addr and mem_wdata are registered and hold their last values outside WRITE. mem_we is 0 outside WRITE.
- core_hold = registered (prg_en | state≠IDLE): rises 1 cycle after prg_en rises, falls 1 cycle after IDLE is re-entered.
- Latency: with latch as the first cycle sampling the pin high, mem_we asserts SYNC_STAGES+2 cycles later. Minimum stable pin high/low time is SYNC_STAGES+1 clk periods.
- Asynchronous reset mid-frame aborts immediately; no write is issued.
- word_count, checksum and frame_err remain readable in IDLE until the next prg_en rise.

Test Plan (ADDR_W=8, DATA_W=8, SYNC_STAGES=2, pins toggled every 4 clk):
- Reset release, prg_en=0, pins toggling → no mem_we, core_hold=0, all outputs 0.
- prg_en=1; shift 17 bits {0,0x10,0xA5}; latch → one mem_we, addr 0x10, data 0xA5, 4 cycles after latch sampled; word_count=1, checksum=0xA5.
- Then three auto frames {1,0xFF,0x01},{1,0x00,0x02},{1,0x33,0x03} → writes at 0x11/0x12/0x13; checksum=0xA5^0x01^0x02^0x03=0xA5; word_count=4.
- Explicit write to 0xFF, then an auto frame → second write to 0x00 (wrap).
- 16 or 18 bits then latch → no write, frame_err=1. A following good frame still writes, and frame_err stays 1.
- prg_en dropped after 9 bits → IDLE, core_hold falls next cycle; re-enable + full frame writes correctly. nreset pulsed mid-frame → all outputs 0, no write.
